// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit pipelined CPU.
// Issues one memory read at a time, parks one word while decode stalls, honours redirect and halt.
module fetch_stage #(
    parameter int              WORD     = 16,
    parameter logic [WORD-1:0] RESET_PC = 16'h0000,
    parameter logic [WORD-1:0] NOP_INST = 16'hF01C
) (
    input  logic            clk,
    input  logic            reset,
    output logic            i_readM,
    output logic [WORD-1:0] i_address,
    input  logic [WORD-1:0] i_data,
    input  logic            i_ready,
    input  logic            stall,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_pc,
    input  logic            halt,
    output logic            ifid_valid,
    output logic [WORD-1:0] ifid_inst,
    output logic [WORD-1:0] ifid_pc,
    output logic [WORD-1:0] ifid_next_pc,
    output logic [3:0]      ifid_opcode,
    output logic [5:0]      ifid_funct
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state_r;
    logic [WORD-1:0] pc_r;
    logic            read_r;
    logic [WORD-1:0] buf_inst_r;
    logic [WORD-1:0] buf_pc_r;
    logic            ifid_valid_r;
    logic [WORD-1:0] ifid_inst_r;
    logic [WORD-1:0] ifid_pc_r;
    logic [WORD-1:0] ifid_next_pc_r;

    function automatic logic [WORD-1:0] pc_incr(input logic [WORD-1:0] v);
        return v + WORD'(1);
    endfunction

    // Fetch FSM, PC, one-word skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_REQ;
            pc_r           <= RESET_PC;
            read_r         <= 1'b1;
            buf_inst_r     <= NOP_INST;
            buf_pc_r       <= {WORD{1'b0}};
            ifid_valid_r   <= 1'b0;
            ifid_inst_r    <= NOP_INST;
            ifid_pc_r      <= {WORD{1'b0}};
            ifid_next_pc_r <= {WORD{1'b0}};
        end else begin
            case (state_r)
                S_REQ: begin
                    if (halt) begin
                        state_r <= S_HALT;
                        read_r  <= 1'b0;
                    end else if (redirect) begin
                        // Data returning in this cycle belongs to the wrong path.
                        pc_r         <= redirect_pc;
                        ifid_valid_r <= 1'b0;
                        ifid_inst_r  <= NOP_INST;
                    end else if (i_ready) begin
                        pc_r <= pc_incr(pc_r);
                        if (stall) begin
                            buf_inst_r <= i_data;
                            buf_pc_r   <= pc_r;
                            state_r    <= S_WAIT;
                            read_r     <= 1'b0;
                        end else begin
                            ifid_valid_r   <= 1'b1;
                            ifid_inst_r    <= i_data;
                            ifid_pc_r      <= pc_r;
                            ifid_next_pc_r <= pc_incr(pc_r);
                        end
                    end else if (!stall) begin
                        ifid_valid_r <= 1'b0;
                        ifid_inst_r  <= NOP_INST;
                    end else begin
                        ifid_valid_r <= ifid_valid_r;
                    end
                end
                S_WAIT: begin
                    if (halt) begin
                        state_r <= S_HALT;
                        read_r  <= 1'b0;
                    end else if (redirect) begin
                        pc_r         <= redirect_pc;
                        ifid_valid_r <= 1'b0;
                        ifid_inst_r  <= NOP_INST;
                        state_r      <= S_REQ;
                        read_r       <= 1'b1;
                    end else if (!stall) begin
                        ifid_valid_r   <= 1'b1;
                        ifid_inst_r    <= buf_inst_r;
                        ifid_pc_r      <= buf_pc_r;
                        ifid_next_pc_r <= pc_incr(buf_pc_r);
                        state_r        <= S_REQ;
                        read_r         <= 1'b1;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_HALT: begin
                    state_r <= S_HALT;
                    read_r  <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: stop fetching until reset.
                    state_r      <= S_HALT;
                    read_r       <= 1'b0;
                    ifid_valid_r <= 1'b0;
                    ifid_inst_r  <= NOP_INST;
                end
            endcase
        end
    end

    assign i_readM      = read_r;
    assign i_address    = pc_r;
    assign ifid_valid   = ifid_valid_r;
    assign ifid_inst    = ifid_inst_r;
    assign ifid_pc      = ifid_pc_r;
    assign ifid_next_pc = ifid_next_pc_r;
    assign ifid_opcode  = ifid_inst_r[WORD-1 -: 4];
    assign ifid_funct   = ifid_inst_r[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// scored against an expected-PC-stream queue consumed by a decoupled monitor.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'hF01C;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        ifid_valid;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_next_pc;
    logic [3:0]  ifid_opcode;
    logic [5:0]  ifid_funct;

    int          passed = 0;
    int          total  = 0;
    int          deliv  = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage #(.WORD(16), .RESET_PC(16'h0000), .NOP_INST(16'hF01C)) dut (
        .clk(clk), .reset(reset), .i_readM(i_readM), .i_address(i_address),
        .i_data(i_data), .i_ready(i_ready), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .ifid_valid(ifid_valid),
        .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_next_pc(ifid_next_pc),
        .ifid_opcode(ifid_opcode), .ifid_funct(ifid_funct)
    );

    function automatic logic [15:0] mem(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Program order from a start address: the stream decode must see, in order.
    task automatic restart_stream(input logic [15:0] start);
        logic [15:0] p;
        p = start;
        exp_q.delete();
        for (int k = 0; k < 512; k++) begin
            exp_q.push_back(p);
            p = p + 16'd1;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory answers with mem[address] only when the bench grants ready and a read is open.
    task automatic drive(input logic rdy, input logic st, input logic rd,
                         input logic [15:0] rpc, input logic hl);
        reset       = 1'b0;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        i_ready     = rdy & i_readM;
        i_data      = i_ready ? mem(i_address) : 16'hDEAD;
        if (rd) restart_stream(rpc);
    endtask

    task automatic do_reset;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        reset = 1'b1;
        restart_stream(16'h0000);
        tick;
        chk("reset_ifid", 64'({ifid_valid, ifid_inst, ifid_pc, ifid_next_pc}),
            64'({1'b0, NOP, 16'h0000, 16'h0000}));
        chk("reset_fetch", 64'({i_readM, i_address}), 64'({1'b1, 16'h0000}));
        reset = 1'b0;
    endtask

    // Decode takes IF/ID at the coming edge when it is valid and nothing blocks it.
    always @(negedge clk) begin : monitor
        logic [15:0] p;
        logic [15:0] ei;
        if (mon_en && !reset && !halt && !redirect && !stall && ifid_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL sb_underflow: got pc %h with no expected entry", ifid_pc);
            end else begin
                p  = exp_q.pop_front();
                ei = mem(p);
                deliv++;
                chk("sb_entry",
                    64'({ifid_inst, ifid_pc, ifid_next_pc, ifid_opcode, ifid_funct}),
                    64'({ei, p, 16'(p + 16'd1), ei[15:12], ei[5:0]}));
            end
        end
    end

    initial begin : stim
        logic        rd_s;
        logic [15:0] rpc_s;
        int          since;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        halt = 1'b0; i_ready = 1'b0; i_data = 16'h0000;
        tick;
        tick;
        do_reset;

        // Single-cycle memory: back-to-back fetches.
        for (int a = 0; a < 4; a++) begin
            chk("seq_addr", 64'({i_readM, i_address}), 64'({1'b1, 16'(a)}));
            drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
            tick;
            chk("seq_ifid", 64'({ifid_valid, ifid_inst, ifid_pc, ifid_next_pc}),
                64'({1'b1, mem(16'(a)), 16'(a), 16'(a + 1)}));
        end

        // Three-cycle latency on address 5.
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
            chk("lat_req", 64'({i_readM, i_address}), 64'({1'b1, 16'h0005}));
            tick;
            chk("lat_bubble", 64'({ifid_valid, ifid_inst}), 64'({1'b0, NOP}));
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk("lat_data", 64'({ifid_valid, ifid_inst, ifid_pc}), 64'({1'b1, 16'h1005, 16'h0005}));

        // Stall while pc=7 returns: word parked, IF/ID held, then released in order.
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
            tick;
            chk("stall_hold", 64'({i_readM, ifid_valid, ifid_pc}), 64'({1'b0, 1'b1, 16'h0006}));
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk("stall_release", 64'({ifid_valid, ifid_inst, ifid_pc, ifid_next_pc, i_readM, i_address}),
            64'({1'b1, 16'h1007, 16'h0007, 16'h0008, 1'b1, 16'h0008}));
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk("stall_next", 64'({ifid_pc, ifid_inst}), 64'({16'h0008, 16'h1008}));

        // Redirect coinciding with ready data, with a parked word, and with stall in REQ.
        drive(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
        tick;
        chk("redir_ready", 64'({ifid_valid, ifid_inst, i_readM, i_address}),
            64'({1'b0, NOP, 1'b1, 16'h0040}));
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk("redir_follow", 64'({ifid_valid, ifid_pc, ifid_inst}), 64'({1'b1, 16'h0040, 16'h1040}));
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        tick;
        drive(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0);
        tick;
        chk("redir_wait", 64'({ifid_valid, ifid_inst, i_readM, i_address}),
            64'({1'b0, NOP, 1'b1, 16'h0040}));
        drive(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
        tick;
        chk("redir_stall_req", 64'({ifid_valid, ifid_inst, i_readM, i_address}),
            64'({1'b0, NOP, 1'b1, 16'h0040}));
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk("redir_after", 64'({ifid_valid, ifid_pc}), 64'({1'b1, 16'h0040}));

        // PC wrap at 16'hFFFF.
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk("wrap", 64'({ifid_valid, ifid_pc, ifid_next_pc, ifid_inst, i_address}),
            64'({1'b1, 16'hFFFF, 16'h0000, mem(16'hFFFF), 16'h0000}));

        // Reset taken while a request is outstanding.
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk("mid_pending", 64'({i_readM, i_address}), 64'({1'b1, 16'h0001}));
        do_reset;

        // Halt freezes everything; only reset recovers.
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        tick;
        chk("halt_enter", 64'({i_readM, ifid_valid, ifid_pc, ifid_inst}),
            64'({1'b0, 1'b1, 16'h0001, 16'h1001}));
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 16'h0080, 1'b0);
            tick;
            chk("halt_frozen", 64'({i_readM, ifid_valid, ifid_pc, ifid_inst, i_address}),
                64'({1'b0, 1'b1, 16'h0001, 16'h1001, 16'h0002}));
        end
        do_reset;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk("halt_restart", 64'({ifid_valid, ifid_pc, ifid_inst}), 64'({1'b1, 16'h0000, 16'h1000}));

        // Randomized run: ready, stall and redirect scored by the monitor.
        mon_en = 1'b1;
        do_reset;
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            rd_s  = ($urandom_range(0, 24) == 0) || (since >= 200);
            rpc_s = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            since = rd_s ? 0 : since + 1;
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, rd_s, rpc_s, 1'b0);
            tick;
        end
        mon_en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rand_progress", 64'(deliv >= 500), 64'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
